// File: rtl/ring_freq_meter_if.sv
// Bus bundle for ring_freq_meter: control inputs, raw ring inputs and
// measurement results. The meter connects through the slave modport; the
// controller (or a bench) drives through the master modport.
interface ring_freq_meter_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic             enable;
    logic             scan;
    logic [CH_W-1:0]  fixed_ch;
    logic             clear_minmax;
    logic [N_CH-1:0]  ring_in;
    logic [CNT_W-1:0] value_out;
    logic [CH_W-1:0]  ch_out;
    logic             value_valid;
    logic             overflow;
    logic [CNT_W-1:0] min_out;
    logic [CNT_W-1:0] max_out;
    logic             busy;

    modport master (
        output enable, scan, fixed_ch, clear_minmax, ring_in,
        input  value_out, ch_out, value_valid, overflow, min_out, max_out, busy
    );

    modport slave (
        input  enable, scan, fixed_ch, clear_minmax, ring_in,
        output value_out, ch_out, value_valid, overflow, min_out, max_out, busy
    );
endinterface

// File: rtl/ring_freq_meter.sv
// Multi-channel ring-oscillator frequency meter.
// Selects one ring input, synchronises it, and counts its rising edges over a
// fixed gate window after a settle period that flushes the synchroniser.
// Each completed window produces a one-cycle valid strobe with a saturating
// count; min/max of the fixed_ch results are tracked one cycle later.
module ring_freq_meter #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1000000,
    parameter int SETTLE_CYCLES = 4
) (
    input logic              fpga_clk1,
    input logic              reset,
    ring_freq_meter_if.slave bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic [2:0]       sync_q;
    logic             ring_sel;
    logic             rise;
    logic [CNT_W-1:0] value_q, value_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             mm_upd_q, mm_upd_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    assign ring_sel = bus.ring_in[cur_ch_q];
    // sync_q[1] is the second synchroniser flop, sync_q[2] the edge-detect flop
    assign rise = sync_q[1] & ~sync_q[2];

    // Two-flop synchroniser plus edge-detect flop on the selected ring input
    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ring_sel};
        end
    end

    // FSM state and measurement datapath registers
    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cur_ch_q <= '0;
            tmr_q    <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            value_q  <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mm_upd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            tmr_q    <= tmr_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            value_q  <= value_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            mm_upd_q <= mm_upd_d;
        end
    end

    // Next-state and datapath logic: settle, gate, publish, reselect channel
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        tmr_d    = tmr_q;
        count_d  = count_q;
        sat_d    = sat_q;
        value_d  = value_q;
        ch_d     = ch_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        mm_upd_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                sat_d   = 1'b0;
                if (bus.enable) begin
                    cur_ch_d = bus.scan ? '0 : bus.fixed_ch;
                    tmr_d    = SETTLE_LAST;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                count_d = '0;
                sat_d   = 1'b0;
                if (tmr_q == '0) begin
                    tmr_d   = GATE_LAST;
                    state_d = S_GATE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_GATE: begin
                if (rise) begin
                    if (count_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DONE: begin
                value_d  = count_q;
                ch_d     = cur_ch_q;
                ovf_d    = sat_q;
                valid_d  = 1'b1;
                // a coincident clear takes priority, so the result is not folded
                mm_upd_d = (cur_ch_q == bus.fixed_ch) && !bus.clear_minmax;
                if (bus.scan) begin
                    cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);
                end else begin
                    cur_ch_d = bus.fixed_ch;
                end
                count_d = '0;
                sat_d   = 1'b0;
                tmr_d   = SETTLE_LAST;
                state_d = S_SETTLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: discard the in-flight window and keep published results
        if (!bus.enable) begin
            state_d  = S_IDLE;
            cur_ch_d = cur_ch_q;
            count_d  = '0;
            sat_d    = 1'b0;
            value_d  = value_q;
            ch_d     = ch_q;
            ovf_d    = ovf_q;
            valid_d  = 1'b0;
            mm_upd_d = 1'b0;
        end
    end

    // Min/max registers, updated one cycle after the published result
    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    // Clear has priority over folding the latest fixed_ch result
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (bus.clear_minmax) begin
            min_d = '1;
            max_d = '0;
        end else if (mm_upd_q) begin
            if (value_q < min_q) min_d = value_q;
            if (value_q > max_q) max_d = value_q;
        end
    end

    assign bus.value_out   = value_q;
    assign bus.ch_out      = ch_q;
    assign bus.value_valid = valid_q;
    assign bus.overflow    = ovf_q;
    assign bus.min_out     = min_q;
    assign bus.max_out     = max_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule
